// File: rtl/ps2_cola_eventos.sv
// PS/2 keyboard receiver: filtered clock, framed byte capture, E0/F0 prefix decode
// and a small event FIFO read through the PicoBlaze port bus.
module ps2_cola_eventos #(
    parameter int         FILTER_LEN  = 8,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         TIMEOUT_CYC = 200000,
    parameter bit         EMIT_MAKE   = 1'b1,
    parameter logic [7:0] PORT_DATA   = 8'h03,
    parameter logic [7:0] PORT_STAT   = 8'h04
) (
    input  logic                          Reloj,
    input  logic                          RST,
    input  logic                          ps2c,
    input  logic                          DATA_IN,
    input  logic [7:0]                    POR_ID,
    input  logic                          RD_STROBE,
    output logic [7:0]                    OUT_PORT,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          EV_PENDING
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q;
    logic                  fall_edge, dat_s;

    state_t                state_q;
    logic [3:0]            bitcnt_q;
    logic [9:0]            shift_q;
    logic [WW-1:0]         wd_q;
    logic                  byte_vld_q, par_set_q, frm_set_q;
    logic [7:0]            byte_q;

    logic                  ext_pend_q, brk_pend_q;
    logic                  ovf_q, par_err_q, frm_err_q;
    logic [9:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         count_q;
    logic [7:0]            out_port_d;
    logic [9:0]            head;
    logic                  empty, full, push, pop, wr_en, rd_stat, err_any;

    // Reset to all-ones so a held-high keyboard clock never looks like an edge.
    always_ff @(posedge Reloj) begin
        if (RST) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= '1;
            fclk_q     <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2c};
            dat_sync_q <= {dat_sync_q[0], DATA_IN};
            filt_q     <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            if (&filt_q)
                fclk_q <= 1'b1;
            else if (~|filt_q)
                fclk_q <= 1'b0;
        end
    end

    assign fall_edge = fclk_q & ~|filt_q;
    assign dat_s     = dat_sync_q[1];

    always_ff @(posedge Reloj) begin
        if (RST) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            wd_q       <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            par_set_q  <= 1'b0;
            frm_set_q  <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            par_set_q  <= 1'b0;
            frm_set_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fall_edge && !dat_s) begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                        wd_q     <= '0;
                    end
                end
                SHIFT: begin
                    if (fall_edge) begin
                        shift_q  <= {dat_s, shift_q[9:1]};
                        wd_q     <= '0;
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9)
                            state_q <= CHECK;
                    end else if (wd_q == WD_MAX) begin
                        state_q   <= IDLE;
                        frm_set_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                CHECK: begin
                    byte_q     <= shift_q[7:0];
                    byte_vld_q <= (^shift_q[8:0]) && shift_q[9];
                    par_set_q  <= ~^shift_q[8:0];
                    frm_set_q  <= ~shift_q[9];
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_any = par_set_q | frm_set_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign push    = byte_vld_q && (byte_q != 8'hE0) && (byte_q != 8'hF0)
                     && (brk_pend_q || EMIT_MAKE);
    assign pop     = RD_STROBE && (POR_ID == PORT_DATA) && !empty;
    assign rd_stat = RD_STROBE && (POR_ID == PORT_STAT);
    // When full, a simultaneous pop frees the slot the push lands in.
    assign wr_en   = push && (!full || pop);
    assign head    = empty ? 10'd0 : mem_q[rp_q];

    always_comb begin
        out_port_d = 8'h00;
        if (POR_ID == PORT_DATA)
            out_port_d = head[7:0];
        else if (POR_ID == PORT_STAT)
            out_port_d = {ovf_q, par_err_q, frm_err_q, 2'b00, head[9], head[8], !empty};
    end

    always_ff @(posedge Reloj) begin
        if (wr_en)
            mem_q[wp_q] <= {ext_pend_q, brk_pend_q, byte_q};
    end

    always_ff @(posedge Reloj) begin
        if (RST) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            OUT_PORT   <= 8'h00;
        end else begin
            if (err_any) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_vld_q) begin
                if (byte_q == 8'hE0)
                    ext_pend_q <= 1'b1;
                else if (byte_q == 8'hF0)
                    brk_pend_q <= 1'b1;
                else begin
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                end
            end
            if (wr_en)
                wp_q <= wp_q + 1'b1;
            if (pop)
                rp_q <= rp_q + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            // Clear-on-read first so an error raised this cycle stays set.
            if (rd_stat) begin
                ovf_q     <= 1'b0;
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end
            if (push && full && !pop)
                ovf_q <= 1'b1;
            if (par_set_q)
                par_err_q <= 1'b1;
            if (frm_set_q)
                frm_err_q <= 1'b1;
            OUT_PORT <= out_port_d;
        end
    end

    assign FIFO_COUNT = count_q;
    assign EV_PENDING = !empty;
endmodule

// File: tb/tb_ps2_cola_eventos.sv
// Bench for ps2_cola_eventos: two instances (make+break and break-only) share the pins
// and are checked against a byte-level event model with queues.
module tb_ps2_cola_eventos;
    localparam int FL = 8, DEPTH = 4, TO = 1000, HP = 30;
    localparam logic [7:0] PD = 8'h03, PS = 8'h04;

    logic       Reloj = 1'b0, RST = 1'b1, ps2c = 1'b1, DATA_IN = 1'b1, RD_STROBE = 1'b0;
    logic [7:0] POR_ID = 8'h00;
    logic [7:0] out0, out1;
    logic [2:0] cnt0, cnt1;
    logic       pend0, pend1;

    always #5 Reloj = ~Reloj;

    ps2_cola_eventos #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .EMIT_MAKE(1'b1),
                       .PORT_DATA(PD), .PORT_STAT(PS)) dut0 (
        .Reloj(Reloj), .RST(RST), .ps2c(ps2c), .DATA_IN(DATA_IN), .POR_ID(POR_ID),
        .RD_STROBE(RD_STROBE), .OUT_PORT(out0), .FIFO_COUNT(cnt0), .EV_PENDING(pend0));

    ps2_cola_eventos #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .EMIT_MAKE(1'b0),
                       .PORT_DATA(PD), .PORT_STAT(PS)) dut1 (
        .Reloj(Reloj), .RST(RST), .ps2c(ps2c), .DATA_IN(DATA_IN), .POR_ID(POR_ID),
        .RD_STROBE(RD_STROBE), .OUT_PORT(out1), .FIFO_COUNT(cnt1), .EV_PENDING(pend1));

    int checks = 0, errors = 0;

    // Reference model: q0 holds every event, q1 only break events.
    logic [9:0] q0[$], q1[$];
    bit ext_p, brk_p, ovf0, ovf1, par_e, frm_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q0.delete(); q1.delete();
        ext_p = 0; brk_p = 0; ovf0 = 0; ovf1 = 0; par_e = 0; frm_e = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [9:0] ev;
        if (b == 8'hE0) ext_p = 1;
        else if (b == 8'hF0) brk_p = 1;
        else begin
            ev = {ext_p, brk_p, b};
            if (q0.size() < DEPTH) q0.push_back(ev); else ovf0 = 1;
            if (brk_p) begin
                if (q1.size() < DEPTH) q1.push_back(ev); else ovf1 = 1;
            end
            ext_p = 0; brk_p = 0;
        end
    endtask

    task automatic m_err(input bit p, input bit f);
        if (p) par_e = 1;
        if (f) frm_e = 1;
        ext_p = 0; brk_p = 0;
    endtask

    function automatic logic [7:0] m_out(input logic [7:0] id, input bit which);
        logic [9:0] h; bit ne, ov;
        if (which) begin ne = q1.size() > 0; h = ne ? q1[0] : 10'd0; ov = ovf1; end
        else       begin ne = q0.size() > 0; h = ne ? q0[0] : 10'd0; ov = ovf0; end
        if (id == PD) return h[7:0];
        if (id == PS) return {ov, par_e, frm_e, 2'b00, h[9], h[8], ne};
        return 8'h00;
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    endfunction

    function automatic logic [7:0] rnd_code();
        logic [7:0] c;
        c = 8'($urandom_range(1, 8'hDF));
        return c;
    endfunction

    // Drives n bits; on the last bit's low phase optionally strobes a DATA pop
    // sampled k cycles after the fall, and/or measures when FIFO_COUNT moves.
    task automatic ps2_bits(input logic [10:0] bits, input int n, input int pop_k,
                            input bit meas, output int lat);
        logic [2:0] cnt_before;
        lat = -1;
        for (int i = 0; i < n; i++) begin
            DATA_IN = bits[i];
            repeat (HP) @(posedge Reloj);
            #1;
            ps2c = 1'b0;
            cnt_before = cnt0;
            for (int k = 1; k <= HP; k++) begin
                @(posedge Reloj);
                #1;
                if (i == n - 1) begin
                    if (k == pop_k - 1) RD_STROBE = 1'b1;
                    if (k == pop_k) RD_STROBE = 1'b0;
                    if (meas && lat < 0 && cnt0 != cnt_before) lat = k;
                end
            end
            ps2c = 1'b1;
        end
        DATA_IN = 1'b1;
    endtask

    task automatic finish_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        repeat (HP) @(posedge Reloj);
        #1;
        if (bad_par || bad_stop) m_err(bad_par, bad_stop);
        else m_byte(code);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        int d;
        ps2_bits(frame_bits(code, bad_par, bad_stop), 11, -1, 0, d);
        finish_frame(code, bad_par, bad_stop);
    endtask

    task automatic rd(input logic [7:0] id, input string tag);
        POR_ID = id;
        repeat (2) @(posedge Reloj);
        #1;
        chk({tag, "_u0"}, out0, m_out(id, 0));
        chk({tag, "_u1"}, out1, m_out(id, 1));
        RD_STROBE = 1'b1;
        @(posedge Reloj);
        #1;
        RD_STROBE = 1'b0;
        if (id == PD) begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
        end else if (id == PS) begin
            ovf0 = 0; ovf1 = 0; par_e = 0; frm_e = 0;
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt0"}, cnt0, q0.size());
        chk({tag, "_pend0"}, pend0, q0.size() > 0);
        chk({tag, "_cnt1"}, cnt1, q1.size());
        chk({tag, "_pend1"}, pend1, q1.size() > 0);
    endtask

    task automatic drain(input string tag);
        while (q0.size() > 0 || q1.size() > 0) begin
            rd(PS, {tag, "_stat"});
            rd(PD, {tag, "_data"});
        end
        chk_cnt({tag, "_empty"});
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [7:0] c, cs[7];
        int lat, d;
        bit e, b;

        m_reset();
        repeat (4) @(posedge Reloj);
        #1;
        chk("rst_out0", out0, 8'h00);
        chk("rst_out1", out1, 8'h00);
        chk_cnt("rst");
        RST = 1'b0;
        repeat (3) @(posedge Reloj);
        #1;

        // Single make code
        send_frame(8'h1C, 0, 0);
        chk("mk_pend", pend0, 1'b1);
        chk_cnt("mk");
        rd(PS, "mk_stat");
        rd(PD, "mk_data");
        chk_cnt("mk_after");

        // Extended break, then a bare make
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        chk_cnt("eb");
        rd(PS, "eb_stat");
        rd(PD, "eb_data");
        send_frame(8'h75, 0, 0);
        chk_cnt("bare");
        drain("bare");

        // Random prefix combinations
        for (int it = 0; it < 6; it++) begin
            c = rnd_code();
            e = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (e) send_frame(8'hE0, 0, 0);
            if (b) send_frame(8'hF0, 0, 0);
            send_frame(c, 0, 0);
            chk_cnt("rnd");
            drain("rnd");
        end

        // Parity error, clear on read, then normal traffic
        send_frame(8'h72, 1, 0);
        chk_cnt("par");
        rd(PS, "par_stat1");
        rd(PS, "par_stat2");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h72, 0, 0);
        drain("par_after");

        // Stop bit low
        send_frame(8'h29, 0, 1);
        rd(PS, "stop_stat");
        drain("stop_after");

        // Watchdog: pending break prefix must be discarded by the timeout
        send_frame(8'hF0, 0, 0);
        ps2_bits(frame_bits(8'h33, 0, 0), 5, -1, 0, d);
        repeat (TO + 100) @(posedge Reloj);
        #1;
        m_err(0, 1);
        chk_cnt("to");
        rd(PS, "to_stat");
        send_frame(8'h6B, 0, 0);
        chk_cnt("to_next");
        drain("to_next");

        // Short glitch on the keyboard clock with data low
        DATA_IN = 1'b0;
        ps2c = 1'b0;
        repeat (FL - 1) @(posedge Reloj);
        #1;
        ps2c = 1'b1;
        repeat (5) @(posedge Reloj);
        #1;
        DATA_IN = 1'b1;
        repeat (HP) @(posedge Reloj);
        #1;
        c = rnd_code();
        send_frame(8'hF0, 0, 0);
        send_frame(c, 0, 0);
        chk_cnt("glitch");
        drain("glitch");

        // Reset mid-frame with an event queued and an extended prefix pending
        send_frame(8'h5A, 0, 0);
        send_frame(8'hE0, 0, 0);
        ps2_bits(frame_bits(8'h11, 0, 0), 5, -1, 0, d);
        RST = 1'b1;
        @(posedge Reloj);
        #1;
        m_reset();
        chk("rstmid_out0", out0, 8'h00);
        chk_cnt("rstmid");
        @(posedge Reloj);
        #1;
        RST = 1'b0;
        repeat (HP) @(posedge Reloj);
        #1;
        send_frame(8'h74, 0, 0);
        chk_cnt("rst_74");
        rd(PS, "rst_74_stat");
        rd(PD, "rst_74_data");
        drain("rst_74");

        // Overflow and simultaneous push/pop when full
        for (int i = 0; i < 7; i++) cs[i] = rnd_code();
        for (int i = 0; i < 3; i++) send_frame(cs[i], 0, 0);
        ps2_bits(frame_bits(cs[3], 0, 0), 11, -1, 1, lat);
        finish_frame(cs[3], 0, 0);
        chk("lat_bound", (lat >= 3 && lat <= FL + 6), 1'b1);
        send_frame(cs[4], 0, 0);
        send_frame(cs[5], 0, 0);
        chk("ovf_cnt4", cnt0, 3'd4);
        chk_cnt("ovf");
        rd(PS, "ovf_stat");
        POR_ID = PD;
        repeat (2) @(posedge Reloj);
        #1;
        chk("sim_head", out0, m_out(PD, 0));
        ps2_bits(frame_bits(cs[6], 0, 0), 11, lat, 0, d);
        if (q0.size() > 0) void'(q0.pop_front());
        finish_frame(cs[6], 0, 0);
        chk("sim_cnt4", cnt0, 3'd4);
        chk_cnt("sim");
        rd(PS, "sim_stat");
        drain("sim");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
